icache_refill_front: RTL
========================

Name: icache_refill_front

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and the SRAM-to-AXI bridge's instruction port.
- Hits return from internal arrays one cycle after acceptance.
- Misses issue one line-aligned 4-beat burst read (16-byte line) on the bridge's inst port, fill the line, then return the requested word.
- Fetch can be cancelled on redirect; the refill still completes, but its response is suppressed.

Parameters:
SETS, 64, number of lines; power of two, 4..256
IDX_W, $clog2(SETS), index width; tag width = 28 - IDX_W

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cpu_req  in  1  fetch request valid
cpu_addr  in  32  fetch address; bits [1:0] ignored
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  fetch data valid (single-cycle pulse)
cpu_rdata  out  32  fetch data
cpu_cancel  in  1  branch taken or flush; drop the pending response
inv_all  in  1  invalidate all lines (taken only in IDLE)
inst_sram_req  out  1  bridge read request
inst_sram_size  out  2  constant 2'b10
inst_sram_addr  out  32  {tag, index, 4'b0}
inst_sram_addr_ok  in  1  bridge accepted address
inst_sram_data_ok  in  1  one beat valid (one pulse per beat)
inst_sram_rdata  in  32  beat data
rlast_inst  in  1  final beat; coincides with the 4th data_ok

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all valid bits=0; beat counter=0; cancel flag=0.
  - cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0, inst_sram_req=0, inst_sram_addr=0.
- Storage: valid[SETS], tag[SETS][tag_w], data[SETS][4][32], all in flops. Word select is addr[3:2].
- IDLE:
  - cpu_addr_ok = cpu_req & ~inv_all (combinational).
  - On accept: latch the address, go to LOOKUP.
  - If inv_all=1: clear all valid bits this cycle, accept nothing.
- LOOKUP:
  - hit = valid & tag match.
  - On hit: cpu_data_ok=1 with the word, unless cancel applies. Then go to IDLE.
  - A new request may be accepted in the same cycle as a hit (addr_ok in LOOKUP when hit): back-to-back hits give one word per cycle.
  - On miss: go to MISS.
- MISS:
  - inst_sram_req=1, addr line-aligned; hold both stable until inst_sram_addr_ok.
  - Then go to REFILL with beat counter=0.
- REFILL:
  - Each inst_sram_data_ok writes data[idx][cnt], then cnt++ (2-bit).
  - Beats are in ascending word order starting at word 0.
  - On data_ok & rlast_inst: set valid and tag, go to RESP.
  - rlast_inst with cnt≠3 is a protocol error: the line is still marked valid (assertion in the bench).
- RESP:
  - cpu_data_ok=1 with the requested word, taken from the filled array, unless cancel applies. Then go to IDLE.
  - No new accept in RESP.
- Cancel:
  - cpu_cancel in LOOKUP / MISS / REFILL / RESP sets the cancel flag. The flag clears on return to IDLE.
  - cpu_cancel in the same cycle as the would-be data_ok also suppresses it.
  - A bridge request already issued is never withdrawn. The line fill always completes and stays valid.
- Latency:
  - Hit: data 1 cycle after addr_ok.
  - Miss: 2 + bridge latency + 4 beats + 1.
- Simultaneous events:
  - inv_all outside IDLE is ignored; the requester holds it until IDLE.
  - cpu_req in MISS / REFILL / RESP is not accepted.
- No write path. Self-modifying code is handled by inv_all.

Optional Feature:
ICACHE_PERF_CNT_EN
- Defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP→MISS.
  - Cancelled accesses still count.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no ports, no logic.

Decomposition:
- Package icache_pkg: LINE_WORDS=4, OFFSET_W=4, state encoding (IDLE, LOOKUP, MISS, REFILL, RESP), INST_SIZE_WORD=2'b10.
- One sub-module: icache_line_store, holding the valid/tag/data arrays with a lookup read port, a beat write port, and a valid set/clear-all port.
- The FSM and cancel logic stay in the top.

Test Plan:
- Cold miss at 0x1C000008: one bridge req, addr=0x1C000000, size=2'b10. Beats 0x11, 0x22, 0x33, 0x44 with rlast on beat 4 → cpu_data_ok with rdata=0x33.
- Back-to-back hits at 0x1C000000, 0x1C000004, 0x1C00000C after the fill → three consecutive data_ok with 0x11, 0x22, 0x44; inst_sram_req stays 0.
- Conflict miss with SETS=64 at 0x1C000400 (same index 0) → new refill; then 0x1C000000 misses again.
- cpu_cancel pulsed in REFILL beat 2 → all 4 beats absorbed, no cpu_data_ok; a re-fetch of the same address hits one cycle later.
- inst_sram_addr_ok delayed 5 cycles → req and addr held constant, no duplicate request.
- inv_all in IDLE after a fill → the next fetch to the same line misses. resetn low mid-REFILL → outputs return to reset values asynchronously and all lines are invalid.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the instruction cache front end.
package icache_pkg;

  localparam int unsigned LINE_WORDS     = 4;
  localparam int unsigned OFFSET_W       = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_RESP
  } icache_state_e;

endpackage : icache_pkg

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
// One combinational lookup port, one beat write port, and a valid
// set / clear-all port. Only the valid bits are reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 28 - IDX_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_word_sel,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_word_sel,
  input  logic [31:0]      wr_data,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             clr_all
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];
  logic [31:0]      data_d [SETS][LINE_WORDS];

  // Next array contents from the write, set and clear ports.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (set_en) begin
      valid_d[set_idx] = 1'b1;
    end
    if (set_en) begin
      tag_d[set_idx] = set_tag;
    end
    if (wr_en) begin
      data_d[wr_idx][wr_word_sel] = wr_data;
    end
  end

  // Valid bits are the only reset state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Combinational lookup read port.
  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_word  = data_q[rd_idx][rd_word_sel];
  end

endmodule : icache_line_store

// File: rtl/icache_refill_front.sv
// Direct-mapped read-only instruction cache in front of the bridge inst port.
// Hits answer one cycle after acceptance; misses issue one 4-beat line burst.
// Optional macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_refill_front
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        cpu_cancel,
  input  logic        inv_all,
  output logic        inst_sram_req,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
`ifdef ICACHE_PERF_CNT_EN
  input  logic        rlast_inst,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`else
  input  logic        rlast_inst
`endif
);

  localparam int unsigned TAG_W = 28 - IDX_W;

  icache_state_e state_q, state_d;
  logic [31:2]   addr_q, addr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          cancel_q, cancel_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       wsel;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;
  logic             hit;
  logic             accept;
  logic             beat;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  // Field split of the latched fetch address.
  always_comb begin
    idx  = addr_q[OFFSET_W +: IDX_W];
    tag  = addr_q[31 -: TAG_W];
    wsel = addr_q[3:2];
    beat = (state_q == ST_REFILL) && inst_sram_data_ok;
  end

  icache_line_store #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk         (clk),
    .resetn      (resetn),
    .rd_idx      (idx),
    .rd_word_sel (wsel),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word     (rd_word),
    .wr_en       (beat),
    .wr_idx      (idx),
    .wr_word_sel (cnt_q),
    .wr_data     (inst_sram_rdata),
    .set_en      (beat && rlast_inst),
    .set_idx     (idx),
    .set_tag     (tag),
    .clr_all     ((state_q == ST_IDLE) && inv_all)
  );

  // Hit detection and request acceptance (IDLE, or LOOKUP on a hit).
  always_comb begin
    hit    = (state_q == ST_LOOKUP) && rd_valid && (rd_tag == tag);
    accept = 1'b0;
    if (state_q == ST_IDLE) begin
      accept = cpu_req && !inv_all;
    end else if (hit) begin
      accept = cpu_req;
    end
  end

  // State, address, beat counter and cancel flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
    end
  end

  // Next-state logic; a hit that accepts a new fetch starts it with a clean
  // cancel flag even though the FSM never passes through IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    cancel_d = cancel_q;
    unique case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (accept) begin
          addr_d  = cpu_addr[31:2];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          cancel_d = 1'b0;
          if (accept) begin
            addr_d  = cpu_addr[31:2];
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_MISS;
          if (cpu_cancel) cancel_d = 1'b1;
        end
      end
      ST_MISS: begin
        if (cpu_cancel) cancel_d = 1'b1;
        if (inst_sram_addr_ok) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
        end
      end
      ST_REFILL: begin
        if (cpu_cancel) cancel_d = 1'b1;
        if (inst_sram_data_ok) begin
          cnt_d = cnt_q + 2'd1;
          if (rlast_inst) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU and bridge outputs.
  always_comb begin
    cpu_addr_ok    = accept;
    cpu_data_ok    = 1'b0;
    cpu_rdata      = '0;
    inst_sram_req  = (state_q == ST_MISS);
    inst_sram_size = INST_SIZE_WORD;
    inst_sram_addr = '0;
    if (hit || (state_q == ST_RESP)) begin
      cpu_data_ok = !cancel_q && !cpu_cancel;
    end
    if (cpu_data_ok) begin
      cpu_rdata = rd_word;
    end
    if (state_q == ST_MISS) begin
      inst_sram_addr = {addr_q[31:4], 4'b0000};
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters; cancelled accesses still count.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if ((state_q == ST_LOOKUP) && !hit && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule : icache_refill_front
